// File: rtl/gpr_wb_sched.sv
// gpr_wb_sched: arbitrates the single GPR write port between pipeline WB and a late requester,
// and keeps the late-op scoreboard. Define GPR_WB_TRACE_EN for a write/protocol trace.
module gpr_wb_sched #(
    parameter int STARVE_MAX = 3,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          wb_we,
    input  logic [4:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic [DW-1:0] wb_pc,
    output logic          wb_stall,
    input  logic          lw_valid,
    input  logic [4:0]    lw_addr,
    input  logic [DW-1:0] lw_data,
    input  logic [DW-1:0] lw_pc,
    output logic          lw_ready,
    input  logic          rsv_valid,
    input  logic [4:0]    rsv_addr,
    output logic          rsv_ok,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    output logic          id_stall,
    output logic          gpr_we,
    output logic [4:0]    gpr_waddr,
    output logic [DW-1:0] gpr_wd,
    output logic [DW-1:0] gpr_pc,
    output logic [31:0]   busy
);

    localparam int            CW      = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;
    logic          grant_lw;
    logic          win_valid;
    logic [4:0]    win_addr;
    logic [DW-1:0] win_data;
    logic [DW-1:0] win_pc;
    logic [31:0]   busy_q;
    logic [31:0]   busy_next;

    // Late requester wins when WB is idle or once it has waited STARVE_MAX cycles.
    assign grant_lw = lw_valid & (~wb_we | (starve_cnt == CNT_MAX));
    assign lw_ready = grant_lw;
    assign wb_stall = wb_we & grant_lw;

    assign rsv_ok   = (rsv_addr == 5'd0) | ~busy_q[rsv_addr];
    // busy_q[0] is held at 0, so register 0 never causes a stall.
    assign id_stall = busy_q[id_rs] | busy_q[id_rt] | busy_q[id_rd];
    assign busy     = busy_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        win_valid = 1'b0;
        win_addr  = wb_addr;
        win_data  = wb_data;
        win_pc    = wb_pc;
        if (grant_lw) begin
            win_valid = 1'b1;
            win_addr  = lw_addr;
            win_data  = lw_data;
            win_pc    = lw_pc;
        end else if (wb_we) begin
            win_valid = 1'b1;
        end
    end

    always_comb begin
        busy_next = busy_q;
        if (grant_lw)
            busy_next[lw_addr] = 1'b0;
        if (rsv_valid && rsv_ok)
            busy_next[rsv_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            starve_cnt <= '0;
        end else if (!lw_valid || grant_lw) begin
            // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    // Output stage: the winner is registered; address-0 writes are consumed without a write.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            // NOTE: the data/PC registers are reset too, so the GPR port shows zeros after reset.
            gpr_we    <= 1'b0;
            gpr_waddr <= '0;
            gpr_wd    <= '0;
            gpr_pc    <= '0;
        end else begin
            gpr_we <= win_valid && (win_addr != 5'd0);
            if (win_valid) begin
                gpr_waddr <= win_addr;
                gpr_wd    <= win_data;
                gpr_pc    <= win_pc;
            end
        end
    end

`ifdef GPR_WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (clr_n) begin
            if (gpr_we)
                $display("%d@%h: $%d <= %h", $time, gpr_pc, gpr_waddr, gpr_wd);
            if (grant_lw && (lw_addr != 5'd0) && !busy_q[lw_addr])
                $display("gpr_wb_sched error: late write to non-busy $%0d", lw_addr);
            if (rsv_valid && !rsv_ok)
                $display("gpr_wb_sched error: reservation of busy $%0d refused", rsv_addr);
        end
    end
`else
    // Default build: no trace logic.
`endif

endmodule
